// File: rtl/board_ctrl.sv
// 4x4 paint board controller: cursor moves and paint edits go to a shadow board,
// which is snapshotted (with a blinking cursor overlay) to x1..x4 once per frame.
module board_ctrl #(
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] CLEAR_COLOR  = 12'h000,
  parameter logic [11:0] CURSOR_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        btnUp,
  input  logic        btnDown,
  input  logic        btnLeft,
  input  logic        btnRight,
  input  logic        btnCenter,
  input  logic        clearReq,
  input  logic [11:0] colorSel,
  input  logic        frameStart,
  output logic [47:0] x1,
  output logic [47:0] x2,
  output logic [47:0] x3,
  output logic [47:0] x4,
  output logic [1:0]  cursorRow,
  output logic [1:0]  cursorCol,
  output logic        busy
);

  typedef enum logic {IDLE, DIRTY} state_t;

  typedef enum logic [2:0] {
    ACT_NONE, ACT_CLEAR, ACT_CENTER, ACT_UP, ACT_DOWN, ACT_LEFT, ACT_RIGHT
  } action_t;

  localparam int                CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  state_t            state;
  action_t           action;
  logic [5:0]        prev;
  logic [5:0]        level;
  logic [5:0]        rise;
  logic [11:0]       shadow [16];
  logic [3:0]        cursor_idx;
  logic [191:0]      commit_flat;
  logic              blink_on;
  logic [CNT_W-1:0]  blink_cnt;

  // Bit order {clear, center, up, down, left, right} matches action priority.
  assign level      = {clearReq, btnCenter, btnUp, btnDown, btnLeft, btnRight};
  assign rise       = level & ~prev;
  assign cursor_idx = {cursorRow, cursorCol};

  always_comb begin
    action = ACT_NONE;
    if      (rise[5]) action = ACT_CLEAR;
    else if (rise[4]) action = ACT_CENTER;
    else if (rise[3]) action = ACT_UP;
    else if (rise[2]) action = ACT_DOWN;
    else if (rise[1]) action = ACT_LEFT;
    else if (rise[0]) action = ACT_RIGHT;
  end

  // Frame image built from the current (pre-edge) shadow; cell i = 4*row + col.
  always_comb begin
    commit_flat = '0;
    for (int i = 0; i < 16; i++) begin
      commit_flat[12*i +: 12] = (blink_on && cursor_idx == 4'(i)) ? CURSOR_COLOR
                                                                   : shadow[4'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      // NOTE: the shadow board is reset cell by cell because a clear board is
      // observable after reset; this costs a reset on every shadow flop.
      for (int i = 0; i < 16; i++) shadow[4'(i)] <= CLEAR_COLOR;
      prev      <= '1;
      cursorRow <= '0;
      cursorCol <= '0;
      blink_on  <= 1'b0;
      blink_cnt <= '0;
      state     <= IDLE;
      busy      <= 1'b0;
      x1        <= {4{CLEAR_COLOR}};
      x2        <= {4{CLEAR_COLOR}};
      x3        <= {4{CLEAR_COLOR}};
      x4        <= {4{CLEAR_COLOR}};
    end else begin
      prev <= level;

      if (frameStart) begin
        x1 <= commit_flat[47:0];
        x2 <= commit_flat[95:48];
        x3 <= commit_flat[143:96];
        x4 <= commit_flat[191:144];
        if (blink_cnt == CNT_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + CNT_W'(1);
        end
      end

      unique case (action)
        ACT_CLEAR: begin
          for (int i = 0; i < 16; i++) shadow[4'(i)] <= CLEAR_COLOR;
          cursorRow <= '0;
          cursorCol <= '0;
        end
        ACT_CENTER: shadow[cursor_idx] <= colorSel;
        ACT_UP:     cursorRow <= cursorRow - 2'd1;
        ACT_DOWN:   cursorRow <= cursorRow + 2'd1;
        ACT_LEFT:   cursorCol <= cursorCol - 2'd1;
        ACT_RIGHT:  cursorCol <= cursorCol + 2'd1;
        default: ;
      endcase

      // An edit landing on a frame pulse keeps the board dirty for the next frame.
      if (action != ACT_NONE) begin
        state <= DIRTY;
        busy  <= 1'b1;
      end else if (frameStart) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/board_ctrl.md
BOARD_CTRL -- requirements
Module: board_ctrl

Interface
REQ-001 SHALL have parameter BLINK_FRAMES, default 30: frames per cursor blink half-period (at least 1).
REQ-002 SHALL have parameter CLEAR_COLOR, default 12'h000: cell color after reset or clear.
REQ-003 SHALL have parameter CURSOR_COLOR, default 12'hFFF: overlay color for the cursor cell during the blink-on phase.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rstN, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have ports btnUp, btnDown, btnLeft, btnRight, btnCenter, input, 1 each: debounced level buttons.
REQ-007 SHALL have port clearReq, input, 1: level request to clear the board.
REQ-008 SHALL have port colorSel, input, 12: RGB444 color written by a paint action.
REQ-009 SHALL have port frameStart, input, 1: one-cycle pulse at the start of each vertical blank.
REQ-010 SHALL have ports x1, x2, x3, x4, output, 48 each: committed rows 0..3; cell c (0 = leftmost) at bits [12c+11:12c].
REQ-011 SHALL have ports cursorRow and cursorCol, output, 2 each: current cursor position, row 0 at the top.
REQ-012 SHALL have port busy, output, 1: high while shadow edits are not yet committed.

Function
REQ-013 SHALL hold a 16-cell x 12-bit shadow board; all edits apply to the shadow only.
REQ-014 SHALL detect rising edges on btnUp, btnDown, btnLeft, btnRight, btnCenter and clearReq against a registered previous value.
REQ-015 SHALL produce exactly one action per rising edge; a held input SHALL NOT repeat.
REQ-016 SHALL apply at most one action per cycle, with priority clear > center > up > down > left > right; lower-priority edges in the same cycle are discarded.
REQ-017 SHALL implement Up/Down as cursorRow -1/+1 mod 4 and Left/Right as cursorCol -1/+1 mod 4, wrapping (row 0 Up -> row 3; col 3 Right -> col 0).
REQ-018 SHALL implement Center as shadow[cursorRow][cursorCol] <= colorSel, visible in the shadow on the next cycle.
REQ-019 SHALL implement Clear as: all shadow cells <= CLEAR_COLOR, and the cursor <= (0,0).
REQ-020 SHALL implement the commit FSM with states IDLE (clean) and DIRTY; busy = (state == DIRTY).
REQ-021 SHALL move IDLE -> DIRTY on any action (move, center or clear), since a move changes the overlay.
REQ-022 SHALL move DIRTY -> IDLE on frameStart when no action occurs in the same cycle.
REQ-023 SHALL stay in, or enter, DIRTY when an action coincides with frameStart.
REQ-024 SHALL load x1..x4 only on cycles where frameStart = 1 (IDLE or DIRTY), from the pre-edge shadow, cursor and blinkOn values.
REQ-025 SHALL commit shadow values unchanged, except the cursor cell, which takes CURSOR_COLOR when blinkOn = 1.
REQ-026 SHALL NOT include a same-cycle edit in that commit; it appears at the next frameStart.
REQ-027 SHALL increment blinkCnt on each frameStart.
REQ-028 SHALL, on the frameStart where blinkCnt = BLINK_FRAMES-1, set blinkCnt <= 0 and toggle blinkOn; the new phase applies from the next commit.
REQ-029 SHALL change outputs between frameStart pulses only for cursorRow, cursorCol and busy.

Reset
REQ-030 SHALL, on any clk edge with rstN = 0, set: x1..x4 = CLEAR_COLOR replicated 4 times; shadow = CLEAR_COLOR; cursor = (0,0); blinkOn = 0; blinkCnt = 0; state = IDLE (busy = 0).
REQ-031 SHALL set all edge-history registers to 1 during reset, so inputs held through reset produce no action.
REQ-032 SHALL abandon any uncommitted edits when reset is asserted mid-operation; reset overrides frameStart and all actions.
REQ-033 SHALL leave the first commit after reset showing no cursor overlay (blinkOn = 0).

Verification
REQ-034 SHALL cover: reset, pulse btnRight x2, btnDown x1 -> cursor (1,2), busy = 1; frameStart -> busy = 0, x2[35:24] = CLEAR_COLOR (blinkOn = 0).
REQ-035 SHALL cover: cursor (0,0), pulse btnUp then btnLeft -> cursor (3,3) (wrap).
REQ-036 SHALL cover: colorSel = 12'hF80, btnCenter at cursor (2,1), no frameStart -> x3 unchanged; after frameStart -> x3[23:12] = 12'hF80.
REQ-037 SHALL cover: btnCenter and frameStart in the same cycle -> that commit excludes the paint, busy stays 1; the next frameStart commits it and busy = 0.
REQ-038 SHALL cover: BLINK_FRAMES = 2, 2 frameStarts -> the 3rd commit shows 12'hFFF at the cursor cell; the 5th commit shows the shadow color.
REQ-039 SHALL cover: btnCenter held through rstN deassertion -> no paint; clearReq and btnUp rising in the same cycle -> board cleared, cursor (0,0).
